// File: rtl/mod_prod_509.sv
// -----------------------------------------------------------------------------
// mod_prod_509
//
// Collects one burst of six 9-bit residues from the upstream mod-509 sum stage
// and multiplies them together modulo 509. Each multiply is bit-serial: one
// bit of the operand per clock, MSB first, using shift-add with a conditional
// subtract. Six multiplies of nine bits take 54 cycles. The product then
// appears on a registered output together with a one-cycle valid strobe.
//
// Ports
//   clk        in   1  rising-edge clock
//   rst        in   1  synchronous, active-high reset
//   in_valid   in   1  element strobe from the upstream out_valid
//   data_in    in   9  element value from the upstream data_out
//   busy       out  1  high while elements are not being accepted
//   drop       out  1  one-cycle pulse for each element refused while busy
//   out_valid  out  1  result strobe
//   data_out   out  9  result word, always < 509
//   out_idx    out  3  index of the word currently on data_out
//
// Optional feature (macro MOD_PROD_PREFIX_EN)
//   When this macro is defined, the running product is latched after each of
//   the six multiplies. The output phase then streams all six prefix products
//   with out_idx 0..5. When it is undefined, only the final product is emitted
//   with out_idx = 0, and no prefix storage is built.
// -----------------------------------------------------------------------------
module mod_prod_509 (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [8:0] data_in,
  output logic       busy,
  output logic       drop,
  output logic       out_valid,
  output logic [8:0] data_out,
  output logic [2:0] out_idx
);

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_MUL     = 2'd1,
    ST_OUT     = 2'd2
  } state_e;

  localparam logic [9:0] MODULUS   = 10'd509;
  localparam logic [2:0] LAST_ELEM = 3'd5;
  localparam logic [3:0] MSB_BIT   = 4'd8;
`ifdef MOD_PROD_PREFIX_EN
  localparam logic [2:0] LAST_WORD = 3'd5;
`else
  localparam logic [2:0] LAST_WORD = 3'd0;
`endif

  // Single conditional subtract. This is valid because every caller passes a
  // value below 2*509.
  function automatic logic [8:0] mod_reduce(input logic [9:0] v);
    logic [9:0] r;
    if (v >= MODULUS) begin
      r = v - MODULUS;
    end else begin
      r = v;
    end
    return r[8:0];
  endfunction

  state_e     state_q;
  logic [2:0] cnt_q;      // next buffer slot during collection
  logic [2:0] k_q;        // which element is being multiplied in
  logic [3:0] bit_q;      // operand bit handled on this step, 8 down to 0
  logic [8:0] acc_q;      // partial product of the current multiply
  logic [8:0] p_q;        // running product
  logic [8:0] x_q [6];    // captured, reduced burst
  logic [2:0] oi_q;       // output word index during the output phase

  logic       busy_q;
  logic       drop_q;
  logic       out_valid_q;
  logic [8:0] data_out_q;
  logic [2:0] out_idx_q;

`ifdef MOD_PROD_PREFIX_EN
  logic [8:0] prefix_q [6];
`endif

  logic [8:0] cur_x_s;
  logic       cur_bit_s;
  logic [8:0] dbl_s;
  logic [8:0] acc_d;
  logic [8:0] word_s;

  // Operand mux: selects the buffer element for the current multiply.
  always_comb begin
    cur_x_s = 9'd0;
    case (k_q)
      3'd0:    cur_x_s = x_q[0];
      3'd1:    cur_x_s = x_q[1];
      3'd2:    cur_x_s = x_q[2];
      3'd3:    cur_x_s = x_q[3];
      3'd4:    cur_x_s = x_q[4];
      3'd5:    cur_x_s = x_q[5];
      default: cur_x_s = 9'd0;
    endcase
  end

  // One shift-add step. First double the partial product and reduce it, then
  // add P and reduce again if the operand bit is set.
  always_comb begin
    cur_bit_s = cur_x_s[bit_q];
    dbl_s     = mod_reduce({acc_q, 1'b0});
    if (cur_bit_s) begin
      acc_d = mod_reduce({1'b0, dbl_s} + {1'b0, p_q});
    end else begin
      acc_d = dbl_s;
    end
  end

  // Word presented during the output phase.
`ifdef MOD_PROD_PREFIX_EN
  always_comb begin
    word_s = 9'd0;
    case (oi_q)
      3'd0:    word_s = prefix_q[0];
      3'd1:    word_s = prefix_q[1];
      3'd2:    word_s = prefix_q[2];
      3'd3:    word_s = prefix_q[3];
      3'd4:    word_s = prefix_q[4];
      3'd5:    word_s = prefix_q[5];
      default: word_s = 9'd0;
    endcase
  end
`else
  always_comb begin
    word_s = p_q;
  end
`endif

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_COLLECT;
      cnt_q       <= 3'd0;
      k_q         <= 3'd0;
      bit_q       <= 4'd0;
      acc_q       <= 9'd0;
      p_q         <= 9'd0;
      oi_q        <= 3'd0;
      busy_q      <= 1'b0;
      drop_q      <= 1'b0;
      out_valid_q <= 1'b0;
      data_out_q  <= 9'd0;
      out_idx_q   <= 3'd0;
      for (int i = 0; i < 6; i++) begin
        x_q[i] <= 9'd0;
      end
`ifdef MOD_PROD_PREFIX_EN
      for (int i = 0; i < 6; i++) begin
        prefix_q[i] <= 9'd0;
      end
`endif
    end else begin
      drop_q      <= 1'b0;
      out_valid_q <= 1'b0;
      data_out_q  <= 9'd0;
      out_idx_q   <= 3'd0;
      case (state_q)
        ST_COLLECT: begin
          busy_q <= 1'b0;
          if (in_valid) begin
            x_q[cnt_q] <= mod_reduce({1'b0, data_in});
            if (cnt_q == LAST_ELEM) begin
              cnt_q   <= 3'd0;
              p_q     <= 9'd1;
              acc_q   <= 9'd0;
              k_q     <= 3'd0;
              bit_q   <= MSB_BIT;
              busy_q  <= 1'b1;
              state_q <= ST_MUL;
            end else begin
              cnt_q <= cnt_q + 3'd1;
            end
          end
        end
        ST_MUL: begin
          busy_q <= 1'b1;
          drop_q <= in_valid;
          if (bit_q == 4'd0) begin
            // The last bit of this operand finishes the multiply.
            p_q   <= acc_d;
            acc_q <= 9'd0;
            bit_q <= MSB_BIT;
`ifdef MOD_PROD_PREFIX_EN
            prefix_q[k_q] <= acc_d;
`endif
            if (k_q == LAST_ELEM) begin
              k_q     <= 3'd0;
              oi_q    <= 3'd0;
              state_q <= ST_OUT;
            end else begin
              k_q <= k_q + 3'd1;
            end
          end else begin
            acc_q <= acc_d;
            bit_q <= bit_q - 4'd1;
          end
        end
        ST_OUT: begin
          // busy stays high for the cycle in which the last word is shown.
          // The state goes back to COLLECT on that same edge, so the next
          // edge can already accept an element.
          busy_q      <= 1'b1;
          drop_q      <= in_valid;
          out_valid_q <= 1'b1;
          data_out_q  <= word_s;
          out_idx_q   <= oi_q;
          if (oi_q == LAST_WORD) begin
            oi_q    <= 3'd0;
            state_q <= ST_COLLECT;
          end else begin
            oi_q <= oi_q + 3'd1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_COLLECT;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign drop      = drop_q;
  assign out_valid = out_valid_q;
  assign data_out  = data_out_q;
  assign out_idx   = out_idx_q;

endmodule

// File: tb/tb_mod_prod_509.sv
module tb_mod_prod_509;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [8:0] data_in;
  logic       busy;
  logic       drop;
  logic       out_valid;
  logic [8:0] data_out;
  logic [2:0] out_idx;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef MOD_PROD_PREFIX_EN
  localparam int NW = 6;
`else
  localparam int NW = 1;
`endif
  localparam int LATENCY = 55;

  mod_prod_509 dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .data_in  (data_in),
    .busy     (busy),
    .drop     (drop),
    .out_valid(out_valid),
    .data_out (data_out),
    .out_idx  (out_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: running products of the reduced elements, using plain
  // integer arithmetic.
  function automatic void model(input logic [8:0] v [6], output int pre [6]);
    int p;
    p = 1;
    for (int i = 0; i < 6; i++) begin
      p = (p * (int'(v[i]) % 509)) % 509;
      pre[i] = p;
    end
  endfunction

  function automatic int exp_word(input int pre [6], input int i);
`ifdef MOD_PROD_PREFIX_EN
    return pre[i];
`else
    return pre[5];
`endif
  endfunction

  function automatic int exp_idx(input int i);
`ifdef MOD_PROD_PREFIX_EN
    return i;
`else
    return 0;
`endif
  endfunction

  // Entered at posedge+1. Returns at posedge+1 right after the 6th capture.
  task automatic drive_burst(input logic [8:0] v [6], input int gmin, input int gmax);
    int g;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      data_in  = v[i];
      @(posedge clk); #1;
      if (i < 5) begin
        g = $urandom_range(gmax, gmin);
        if (g > 0) begin
          in_valid = 1'b0;
          data_in  = 9'd0;
          repeat (g) begin @(posedge clk); #1; end
        end
      end
    end
    in_valid = 1'b0;
    data_in  = 9'd0;
  endtask

  // Counts edges since the last capture until out_valid rises (bounded), then
  // collects the consecutive output words.
  task automatic wait_result(input int start, output int lat, output int nw,
                             output logic [8:0] w [6], output logic [2:0] ix [6],
                             output bit busy_ok, output logic busy_aft,
                             output logic val_aft, output logic [8:0] data_aft);
    int c;
    c = start;
    lat = -1;
    nw = 0;
    busy_ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      w[i]  = 9'd0;
      ix[i] = 3'd0;
    end
    while (lat < 0 && c < 200) begin
      @(posedge clk); #1;
      c++;
      if (out_valid === 1'b1) lat = c;
      else if (busy !== 1'b1) busy_ok = 1'b0;
    end
    while (lat >= 0 && out_valid === 1'b1 && nw < 6) begin
      w[nw]  = data_out;
      ix[nw] = out_idx;
      if (busy !== 1'b1) busy_ok = 1'b0;
      nw++;
      @(posedge clk); #1;
    end
    busy_aft = busy;
    val_aft  = out_valid;
    data_aft = data_out;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    data_in = 9'd77;
    repeat (4) begin @(posedge clk); #1; end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%0b want=0", busy); end
    n_checks++; if (drop !== 1'b0) begin n_fail++; $display("FAIL reset_drop got=%0b want=0", drop); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%0b want=0", out_valid); end
    n_checks++; if (data_out !== 9'd0) begin n_fail++; $display("FAIL reset_data got=%0d want=0", data_out); end
    n_checks++; if (out_idx !== 3'd0) begin n_fail++; $display("FAIL reset_idx got=%0d want=0", out_idx); end
    rst = 1'b0;
    in_valid = 1'b0;
    data_in = 9'd0;
    // A partial burst followed by reset must be forgotten.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      data_in = 9'd100;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL partial_reset_busy got=%0b want=0", busy); end
  endtask

  task automatic test_directed();
    logic [8:0] b [6];
    int pre [6];
    int lat, nw;
    logic [8:0] w [6];
    logic [2:0] ix [6];
    bit bok;
    logic baft, vaft;
    logic [8:0] daft;
    int dv [4][6];
    int dgap [4];
    int dfin [4];
    dv   = '{'{1, 2, 3, 4, 5, 6}, '{508, 508, 508, 508, 508, 508},
             '{7, 0, 9, 9, 9, 9}, '{510, 511, 1, 1, 1, 1}};
    dgap = '{0, 0, 0, 2};
    dfin = '{211, 1, 0, 2};
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 6; i++) b[i] = 9'(dv[t][i]);
      model(b, pre);
      drive_burst(b, dgap[t], dgap[t]);
      wait_result(0, lat, nw, w, ix, bok, baft, vaft, daft);
      n_checks++; if (lat !== LATENCY) begin n_fail++; $display("FAIL dir%0d_latency got=%0d want=%0d", t, lat, LATENCY); end
      n_checks++; if (nw !== NW) begin n_fail++; $display("FAIL dir%0d_words got=%0d want=%0d", t, nw, NW); end
      for (int i = 0; i < NW; i++) begin
        n_checks++; if (w[i] !== 9'(exp_word(pre, i))) begin n_fail++; $display("FAIL dir%0d_data[%0d] got=%0d want=%0d", t, i, w[i], exp_word(pre, i)); end
        n_checks++; if (ix[i] !== 3'(exp_idx(i))) begin n_fail++; $display("FAIL dir%0d_idx[%0d] got=%0d want=%0d", t, i, ix[i], exp_idx(i)); end
      end
      n_checks++; if (w[NW-1] !== 9'(dfin[t])) begin n_fail++; $display("FAIL dir%0d_final got=%0d want=%0d", t, w[NW-1], dfin[t]); end
      n_checks++; if (bok !== 1'b1) begin n_fail++; $display("FAIL dir%0d_busy_hold got=%0b want=1", t, bok); end
      n_checks++; if (baft !== 1'b0) begin n_fail++; $display("FAIL dir%0d_busy_after got=%0b want=0", t, baft); end
      n_checks++; if (vaft !== 1'b0) begin n_fail++; $display("FAIL dir%0d_valid_after got=%0b want=0", t, vaft); end
      n_checks++; if (daft !== 9'd0) begin n_fail++; $display("FAIL dir%0d_data_after got=%0d want=0", t, daft); end
    end
  endtask

  task automatic test_drop();
    logic [8:0] b [6];
    int pre [6];
    int lat, nw;
    logic [8:0] w [6];
    logic [2:0] ix [6];
    bit bok;
    logic baft, vaft;
    logic [8:0] daft;
    for (int i = 0; i < 6; i++) b[i] = 9'(i + 1);
    model(b, pre);
    drive_burst(b, 0, 0);
    repeat (9) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    data_in = 9'd300;
    @(posedge clk); #1;
    in_valid = 1'b0;
    data_in = 9'd0;
    n_checks++; if (drop !== 1'b1) begin n_fail++; $display("FAIL drop_pulse got=%0b want=1", drop); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL drop_busy got=%0b want=1", busy); end
    @(posedge clk); #1;
    n_checks++; if (drop !== 1'b0) begin n_fail++; $display("FAIL drop_clear got=%0b want=0", drop); end
    wait_result(11, lat, nw, w, ix, bok, baft, vaft, daft);
    n_checks++; if (lat !== LATENCY) begin n_fail++; $display("FAIL drop_latency got=%0d want=%0d", lat, LATENCY); end
    n_checks++; if (w[NW-1] !== 9'd211) begin n_fail++; $display("FAIL drop_result got=%0d want=211", w[NW-1]); end
    // Next burst must be accepted normally.
    for (int i = 0; i < 6; i++) b[i] = 9'($urandom_range(511, 0));
    model(b, pre);
    drive_burst(b, 0, 1);
    wait_result(0, lat, nw, w, ix, bok, baft, vaft, daft);
    n_checks++; if (lat !== LATENCY) begin n_fail++; $display("FAIL after_drop_latency got=%0d want=%0d", lat, LATENCY); end
    for (int i = 0; i < NW; i++) begin
      n_checks++; if (w[i] !== 9'(exp_word(pre, i))) begin n_fail++; $display("FAIL after_drop_data[%0d] got=%0d want=%0d", i, w[i], exp_word(pre, i)); end
    end
  endtask

  task automatic test_reset_mid_mul();
    logic [8:0] b [6];
    int pre [6];
    int lat, nw;
    logic [8:0] w [6];
    logic [2:0] ix [6];
    bit bok;
    logic baft, vaft;
    logic [8:0] daft;
    bit seen;
    for (int i = 0; i < 6; i++) b[i] = 9'(i + 1);
    drive_burst(b, 0, 0);
    repeat (19) begin @(posedge clk); #1; end
    rst = 1'b1;
    in_valid = 1'b1;
    data_in = 9'd5;
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    data_in = 9'd0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got=%0b want=0", busy); end
    n_checks++; if (drop !== 1'b0) begin n_fail++; $display("FAIL rstmid_drop got=%0b want=0", drop); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got=%0b want=0", out_valid); end
    n_checks++; if (data_out !== 9'd0) begin n_fail++; $display("FAIL rstmid_data got=%0d want=0", data_out); end
    n_checks++; if (out_idx !== 3'd0) begin n_fail++; $display("FAIL rstmid_idx got=%0d want=0", out_idx); end
    seen = 1'b0;
    repeat (70) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_valid got=%0b want=0", seen); end
    for (int i = 0; i < 6; i++) b[i] = 9'd2;
    model(b, pre);
    drive_burst(b, 0, 0);
    wait_result(0, lat, nw, w, ix, bok, baft, vaft, daft);
    n_checks++; if (lat !== LATENCY) begin n_fail++; $display("FAIL rstmid_latency got=%0d want=%0d", lat, LATENCY); end
    n_checks++; if (w[NW-1] !== 9'd64) begin n_fail++; $display("FAIL rstmid_result got=%0d want=64", w[NW-1]); end
    for (int i = 0; i < NW; i++) begin
      n_checks++; if (w[i] !== 9'(exp_word(pre, i))) begin n_fail++; $display("FAIL rstmid_data[%0d] got=%0d want=%0d", i, w[i], exp_word(pre, i)); end
    end
  endtask

  task automatic test_random();
    logic [8:0] b [6];
    int pre [6];
    int lat, nw;
    logic [8:0] w [6];
    logic [2:0] ix [6];
    bit bok;
    logic baft, vaft;
    logic [8:0] daft;
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 6; i++) begin
        if ($urandom_range(3, 0) == 0) b[i] = 9'($urandom_range(511, 505));
        else b[i] = 9'($urandom_range(511, 0));
      end
      model(b, pre);
      drive_burst(b, 0, 3);
      wait_result(0, lat, nw, w, ix, bok, baft, vaft, daft);
      n_checks++; if (lat !== LATENCY) begin n_fail++; $display("FAIL rnd%0d_latency got=%0d want=%0d", t, lat, LATENCY); end
      n_checks++; if (nw !== NW) begin n_fail++; $display("FAIL rnd%0d_words got=%0d want=%0d", t, nw, NW); end
      for (int i = 0; i < NW; i++) begin
        n_checks++; if (w[i] !== 9'(exp_word(pre, i))) begin n_fail++; $display("FAIL rnd%0d_data[%0d] got=%0d want=%0d", t, i, w[i], exp_word(pre, i)); end
        n_checks++; if (ix[i] !== 3'(exp_idx(i))) begin n_fail++; $display("FAIL rnd%0d_idx[%0d] got=%0d want=%0d", t, i, ix[i], exp_idx(i)); end
      end
      n_checks++; if (bok !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_busy_hold got=%0b want=1", t, bok); end
      n_checks++; if (vaft !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_valid_after got=%0b want=0", t, vaft); end
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] a [6];
    logic [8:0] b [6];
    int pre [6];
    int lat, nw;
    logic [8:0] w [6];
    logic [2:0] ix [6];
    bit bok;
    logic baft, vaft;
    logic [8:0] daft;
    for (int i = 0; i < 6; i++) a[i] = 9'($urandom_range(511, 0));
    for (int i = 0; i < 6; i++) b[i] = 9'($urandom_range(511, 0));
    model(b, pre);
    drive_burst(a, 0, 0);
    // First element of the next burst lands on the earliest accepting edge.
    repeat (54 + NW) begin @(posedge clk); #1; end
    drive_burst(b, 0, 0);
    wait_result(0, lat, nw, w, ix, bok, baft, vaft, daft);
    n_checks++; if (lat !== LATENCY) begin n_fail++; $display("FAIL b2b_latency got=%0d want=%0d", lat, LATENCY); end
    for (int i = 0; i < NW; i++) begin
      n_checks++; if (w[i] !== 9'(exp_word(pre, i))) begin n_fail++; $display("FAIL b2b_data[%0d] got=%0d want=%0d", i, w[i], exp_word(pre, i)); end
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    data_in = 9'd0;
    @(posedge clk); #1;
    test_reset();
    test_directed();
    test_drop();
    test_reset_mid_mul();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired before the end of the test sequence");
    $fatal(1);
  end

endmodule
